// File: rtl/vida_pkg.sv
// Shared types and helpers for the lives monitor: FSM states, error ceiling, LED thermometer.
// Latency: n/a (package); backpressure: n/a.
package vida_pkg;

  typedef enum logic [1:0] {
    JOGANDO = 2'd0,
    ALERTA  = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam logic [1:0] MAX_ERROS = 2'd3;

  function automatic logic [2:0] thermometer(input logic [1:0] remaining);
    case (remaining)
      2'd3:    return 3'b111;
      2'd2:    return 3'b011;
      2'd1:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/gerador_piscada.sv
// Blink timer: start re-arms a 2*BLINK_COUNT half-period sequence; done pulses on its last cycle.
// Latency: aviso_blink=1 the cycle after start; backpressure: enable pauses counting.
module gerador_piscada
  import vida_pkg::*;
#(
  parameter int BLINK_CYCLES = 4,
  parameter int BLINK_COUNT  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic aviso_blink,
  output logic done
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int IDX_W = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * BLINK_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             blink_q, blink_d;
  logic             active_q, active_d;
  logic             wrap;

  assign wrap        = active_q && enable && (cnt_q == CNT_LAST);
  assign done        = wrap && (idx_q == IDX_LAST);
  assign aviso_blink = blink_q;

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    blink_d  = blink_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = '0;
      idx_d    = '0;
      blink_d  = 1'b1;
      active_d = 1'b1;
    end else if (active_q && enable) begin
      if (wrap) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
        // Final half-period ends the sequence; lamp goes dark until re-armed.
        if (done) begin
          idx_d    = '0;
          active_d = 1'b0;
          blink_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      blink_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/monitor_vida.sv
// Lives monitor: detects new errors, blinks a warning (play blocked), shows lives, flags game over.
// Latency: erros change at edge k reflected at edge k; backpressure: none, restart only honoured in FIM.
module monitor_vida
  import vida_pkg::*;
#(
  parameter int BLINK_CYCLES = 4,
  parameter int BLINK_COUNT  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] erros,
  input  logic       restart,
  output logic [2:0] leds_vida,
  output logic       aviso,
  output logic       game_over,
  output logic       jogada_ok
);

  estado_t    state_q, state_d;
  logic [1:0] erros_ant_q;
  logic [2:0] leds_q;
  logic       game_over_q;
  logic       jogada_ok_q;
  logic       perda;
  logic       blink_start;
  logic       blink_en;
  logic       aviso_blink;
  logic       blink_done;

  // A decrease (upstream counter reset) is never a loss, only a resync.
  assign perda    = erros > erros_ant_q;
  assign blink_en = (state_q == ALERTA);

  gerador_piscada #(
    .BLINK_CYCLES (BLINK_CYCLES),
    .BLINK_COUNT  (BLINK_COUNT)
  ) u_piscada (
    .clock       (clock),
    .reset       (reset),
    .start       (blink_start),
    .enable      (blink_en),
    .aviso_blink (aviso_blink),
    .done        (blink_done)
  );

  always_comb begin
    state_d     = JOGANDO;
    blink_start = 1'b0;
    case (state_q)
      JOGANDO: begin
        if (perda) begin
          state_d     = ALERTA;
          blink_start = 1'b1;
        end
      end
      ALERTA: begin
        state_d = ALERTA;
        if (perda) begin
          blink_start = 1'b1;
        end else if (blink_done) begin
          state_d = (erros == MAX_ERROS) ? FIM : JOGANDO;
        end
      end
      FIM: begin
        state_d = restart ? JOGANDO : FIM;
      end
      default: begin
        state_d = JOGANDO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= JOGANDO;
      erros_ant_q <= 2'b00;
      leds_q      <= 3'b111;
      game_over_q <= 1'b0;
      jogada_ok_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      erros_ant_q <= erros;
      leds_q      <= thermometer(MAX_ERROS - erros);
      game_over_q <= (state_d == FIM);
      jogada_ok_q <= (state_d == JOGANDO);
    end
  end

  assign leds_vida = leds_q;
  assign game_over = game_over_q;
  assign jogada_ok = jogada_ok_q;
  // Lamp is steady in FIM and follows the blink timer only while alerting.
  assign aviso     = (state_q == FIM) | ((state_q == ALERTA) & aviso_blink);

endmodule

// File: doc/monitor_vida.md
Name: monitor_vida

Overview:
- Sits directly downstream of the life counter and consumes its 2-bit "errors so far" output (00 = no error, 11 = three errors, saturated).
- Detects each new lost life and runs a timed warning blink, during which play is blocked.
- Drives a 3-LED remaining-lives thermometer and asserts game over after the third error.
- Provides a player-restart path out of game over.

Parameters:
- BLINK_CYCLES, 4: clock cycles per blink half-period (on time = off time); must be >= 1.
- BLINK_COUNT, 3: number of full on/off blinks per warning; must be >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clock).
- erros  input  2  errors-so-far count from the life counter, 0..3.
- restart  input  1  player restart request; level, sampled each cycle; acted on only in FIM.
- leds_vida  output  3  remaining-lives thermometer: 3→111, 2→011, 1→001, 0→000.
- aviso  output  1  warning lamp: blinks in ALERTA, steady 1 in FIM.
- game_over  output  1  1 while in FIM.
- jogada_ok  output  1  1 when player input is accepted (JOGANDO only).

Behaviour:
- All outputs registered (Moore); an erros change sampled at edge k is reflected at edge k.
- Reset (reset==0 at edge):
  - state=JOGANDO, erros_ant=00, leds_vida=111, aviso=0, game_over=0, jogada_ok=1.
  - Blink counters cleared.
  - Reset overrides every other input in every state, including mid-ALERTA.
- erros_ant holds the value of erros registered at the previous edge. Loss event: erros > erros_ant (unsigned compare). erros is re-registered into erros_ant every cycle in every state.
- leds_vida = thermometer(3 − erros), updated every cycle in every state.
- States:
  - JOGANDO:
    - Outputs: jogada_ok=1, aviso=0, game_over=0.
    - On loss event → ALERTA. Same edge: aviso=1, half-period counter=0, half-period index=0, jogada_ok=0.
  - ALERTA:
    - Outputs: jogada_ok=0, game_over=0.
    - The half-period counter counts 0..BLINK_CYCLES−1.
    - On wrap: aviso toggles and the half-period index increments.
    - When the index reaches 2*BLINK_COUNT, leave ALERTA.
    - Total ALERTA length is exactly 2*BLINK_COUNT*BLINK_CYCLES cycles; defaults give 24 cycles (aviso 1 for 4 cycles, 0 for 4 cycles, ×3).
    - Exit target: if erros==3 → FIM, else → JOGANDO.
  - FIM:
    - Outputs: game_over=1, aviso=1, jogada_ok=0.
    - restart==1 → JOGANDO next edge, with aviso=0 and game_over=0. The upstream counter is reset independently; a subsequent erros decrease is not an event.
- Boundary conditions:
  - Loss event during ALERTA: the blink sequence restarts from the beginning (counters to 0, aviso=1); duration measured from the new event.
  - erros decrease (upstream counter reset) in any state: no event. erros_ant resyncs and leds update; state is unchanged, except that ALERTA still completes its blink and then exits per the exit rule.
  - Jump of erros by 2 (e.g. 01→11) in one cycle: a single event and a single blink sequence; exit to FIM.
  - erros==3 at the edge after reset: counts as a loss event (erros_ant=00), giving ALERTA then FIM.
  - restart outside FIM: ignored.
  - Unused/illegal state encodings recover to JOGANDO on the next edge with reset outputs.

Decomposition:
- Package vida_pkg holds:
  - State enum: JOGANDO, ALERTA, FIM.
  - Constant MAX_ERROS=2'd3.
  - Function thermometer(remaining) returning the 3-bit LED code.
- Sub-module gerador_piscada is the blink timer:
  - Inputs: clock, reset, start, enable.
  - Outputs: aviso_blink, done.
  - Parameterised by BLINK_CYCLES and BLINK_COUNT.
  - start re-arms it.
  - done is a 1-cycle pulse on the last cycle of the sequence.
- monitor_vida contains the FSM, erros_ant register and output registers.

Test Plan:
1. Reset held 0 for 2 cycles, then released with erros=00 → leds_vida=111, aviso=0, game_over=0, jogada_ok=1; stable for 10 cycles.
2. erros 00→01 → next edge: state ALERTA, jogada_ok=0, leds_vida=011. With defaults, aviso pattern 1111 0000 ×3 over 24 cycles, then JOGANDO with jogada_ok=1, aviso=0.
3. Step erros 01→10→11, each after ALERTA ends → leds_vida 001 then 000. After the third blink sequence: game_over=1, aviso=1 steady. restart pulse 1 cycle → next edge game_over=0, jogada_ok=1.
4. erros 00→01, then 01→10 at cycle 10 of ALERTA → blink restarts at cycle 10 and ALERTA ends 24 cycles later (34 total); leds_vida=001.
5. erros 01→11 in one cycle → exactly one 24-cycle ALERTA, then FIM.
6. reset=0 asserted at cycle 5 of ALERTA → next edge JOGANDO, aviso=0, jogada_ok=1, leds_vida=111 (with erros driven 00); restart pulsed in JOGANDO → no change.
